// File: rtl/perceptron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_pkg
//  Description : Shared definitions for the perceptron table trainer:
//                default parameter values, derived sizes, weight/sum types,
//                trainer FSM states and the symmetric saturating add.
//  Optional    : PERCEPTRON_ADAPTIVE_THETA_EN (used by the top level only)
//  Revision    : 1.0 - initial release
// ============================================================================
package perceptron_pkg;

   // Default configuration
   localparam int DEF_ROWS     = 64;
   localparam int DEF_HIST_LEN = 62;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_LANES    = 16;
   localparam int DEF_THETA    = 133;
   localparam int DEF_TC_W     = 7;

   // Sizes derived from the defaults
   localparam int NUM_W = DEF_HIST_LEN + 1;
   localparam int BEATS = (NUM_W + DEF_LANES - 1) / DEF_LANES;
   localparam int SUM_W = DEF_WIDTH + $clog2(NUM_W) + 1;
   localparam int IDX_W = $clog2(DEF_ROWS);

   typedef logic signed [DEF_WIDTH-1:0] weight_t;
   typedef logic signed [SUM_W-1:0]     sum_t;

   typedef enum logic {
      IDLE   = 1'b0,
      UPDATE = 1'b1
   } state_t;

   // Add d to w and clamp to the symmetric range [-lim, +lim]; the
   // most-negative two's-complement code is therefore never produced.
   function automatic int sat_add(input int w, input int d, input int lim);
      int s;
      s = w + d;
      if (s > lim) begin
         return lim;
      end
      if (s < -lim) begin
         return -lim;
      end
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/perceptron_lane_update.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_lane_update
//  Description : Combinational LANES-wide saturating +/-1 weight update.
//                Each lane adds t*x, where t is +1 for taken / -1 for not
//                taken and x is +1 / -1 from the lane's input bit; that is
//                +1 when the two agree and -1 when they differ.
//  Ports       : outcome_i  resolved direction (1 = taken)
//                x_i        per-lane input bit (1 means x = +1)
//                w_i        LANES packed signed weights, lane 0 in LSBs
//                w_o        updated weights, same packing
//  Revision    : 1.0 - initial release
// ============================================================================
module perceptron_lane_update #(
   parameter int LANES = 16,
   parameter int WIDTH = 8
) (
   input  logic                   outcome_i,
   input  logic [LANES-1:0]       x_i,
   input  logic [LANES*WIDTH-1:0] w_i,
   output logic [LANES*WIDTH-1:0] w_o
);
   import perceptron_pkg::*;

   localparam int W_LIM = 2**(WIDTH-1) - 1;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [WIDTH-1:0] w_cur;
      assign w_cur = w_i[l*WIDTH +: WIDTH];
      assign w_o[l*WIDTH +: WIDTH] =
         WIDTH'(sat_add(int'(w_cur), (x_i[l] == outcome_i) ? 1 : -1, W_LIM));
   end

endmodule
`default_nettype wire

// File: rtl/perceptron_table_trainer.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_table_trainer
//  Description : Perceptron weight table with training engine. The table
//                holds ROWS rows of HIST_LEN+1 signed weights (weight 0 is
//                the bias). A resolved branch is checked against the training
//                rule; if training is needed the row is rewritten LANES
//                weights per cycle with symmetric saturating arithmetic.
//  Optional    : PERCEPTRON_ADAPTIVE_THETA_EN - adapts the training
//                threshold with a TC_W-bit signed counter. Without it the
//                threshold is the constant THETA.
//  Ports       : clk, rst       clock, asynchronous active-high reset
//                pred_row       row read by the predictor
//                pred_weights   combinational read of pred_row (pre-write)
//                train_valid/train_ready  training request handshake
//                train_row, train_history, train_outcome, train_sum
//                               request payload
//                busy, busy_row row rewrite in progress and its row
//                train_done     one-cycle pulse on the final write beat
//                cur_theta      threshold currently in use
//  Revision    : 1.0 - initial release
// ============================================================================
module perceptron_table_trainer #(
   parameter int ROWS     = perceptron_pkg::DEF_ROWS,
   parameter int HIST_LEN = perceptron_pkg::DEF_HIST_LEN,
   parameter int WIDTH    = perceptron_pkg::DEF_WIDTH,
   parameter int LANES    = perceptron_pkg::DEF_LANES,
   parameter int THETA    = perceptron_pkg::DEF_THETA,
   parameter int TC_W     = perceptron_pkg::DEF_TC_W
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [$clog2(ROWS)-1:0]                           pred_row,
   output logic [(HIST_LEN+1)*WIDTH-1:0]                     pred_weights,
   input  logic                                              train_valid,
   output logic                                              train_ready,
   input  logic [$clog2(ROWS)-1:0]                           train_row,
   input  logic [HIST_LEN-1:0]                               train_history,
   input  logic                                              train_outcome,
   input  logic [WIDTH+$clog2(HIST_LEN+1):0]                 train_sum,
   output logic                                              busy,
   output logic [$clog2(ROWS)-1:0]                           busy_row,
   output logic                                              train_done,
   output logic [WIDTH+$clog2(HIST_LEN+1):0]                 cur_theta
);
   localparam int NUM_W  = HIST_LEN + 1;
   localparam int BEATS  = (NUM_W + LANES - 1) / LANES;
   localparam int SUM_W  = WIDTH + $clog2(NUM_W) + 1;
   localparam int IDX_W  = $clog2(ROWS);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ROW_W  = NUM_W * WIDTH;

   import perceptron_pkg::*;

   // ------------------------------------------------------------------
   // Storage and registers
   // ------------------------------------------------------------------
   logic [ROW_W-1:0]    table_q [ROWS];

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    row_q, row_d;
   logic [HIST_LEN-1:0] hist_q, hist_d;
   logic                outcome_q, outcome_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;

   logic [SUM_W-1:0]    w_theta;

   // ------------------------------------------------------------------
   // Training decision on the incoming request
   // ------------------------------------------------------------------
   logic                w_sum_neg;
   logic                w_mispredict;
   logic [SUM_W:0]      w_sum_ext;
   logic [SUM_W:0]      w_abs;
   logic                w_need_train;

   assign w_sum_neg    = train_sum[SUM_W-1];
   assign w_mispredict = (~w_sum_neg) != train_outcome;
   // One extra bit so that negating the most-negative sum cannot overflow.
   assign w_sum_ext    = {train_sum[SUM_W-1], train_sum};
   assign w_abs        = w_sum_neg ? -w_sum_ext : w_sum_ext;
   assign w_need_train = w_mispredict || (w_abs <= {1'b0, w_theta});

   // ------------------------------------------------------------------
   // Row rewrite datapath
   // ------------------------------------------------------------------
   logic [ROW_W-1:0]       w_row_cur;
   logic [ROW_W-1:0]       w_row_new;
   logic [NUM_W-1:0]       w_xv;
   logic [LANES*WIDTH-1:0] w_lane_w;
   logic [LANES-1:0]       w_lane_x;
   logic [LANES*WIDTH-1:0] w_lane_o;

   assign w_row_cur = table_q[row_q];
   // Input vector for the whole row: the bias input is always +1.
   assign w_xv      = {hist_q, 1'b1};

   // Gather the weights belonging to the current beat; lanes that fall
   // past the last weight on the final beat see zeros and are discarded.
   always_comb begin
      w_lane_w = '0;
      w_lane_x = '0;
      for (int k = 0; k < NUM_W; k++) begin
         if ((k / LANES) == int'(beat_q)) begin
            w_lane_w[(k % LANES)*WIDTH +: WIDTH] = w_row_cur[k*WIDTH +: WIDTH];
            w_lane_x[k % LANES]                  = w_xv[k];
         end
      end
   end

   perceptron_lane_update #(
      .LANES (LANES),
      .WIDTH (WIDTH)
   ) u_lane_update (
      .outcome_i (outcome_q),
      .x_i       (w_lane_x),
      .w_i       (w_lane_w),
      .w_o       (w_lane_o)
   );

   always_comb begin
      w_row_new = w_row_cur;
      for (int k = 0; k < NUM_W; k++) begin
         if ((k / LANES) == int'(beat_q)) begin
            w_row_new[k*WIDTH +: WIDTH] = w_lane_o[(k % LANES)*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++) begin
            table_q[r] <= '0;
         end
      end else if (state_q == UPDATE) begin
         table_q[row_q] <= w_row_new;
      end
   end

   // The read sees the registered table, so a same-cycle write is not
   // forwarded and a row under rewrite may be partially updated.
   assign pred_weights = table_q[pred_row];

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         row_q     <= '0;
         hist_q    <= '0;
         outcome_q <= 1'b0;
         beat_q    <= '0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         hist_q    <= hist_d;
         outcome_q <= outcome_d;
         beat_q    <= beat_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      hist_d      = hist_q;
      outcome_d   = outcome_q;
      beat_d      = beat_q;
      train_ready = 1'b0;
      train_done  = 1'b0;
      case (state_q)
         IDLE: begin
            train_ready = 1'b1;
            // A request that needs no training is simply consumed here.
            if (train_valid && w_need_train) begin
               row_d     = train_row;
               hist_d    = train_history;
               outcome_d = train_outcome;
               beat_d    = '0;
               state_d   = UPDATE;
            end
         end
         UPDATE: begin
            if (beat_q == BEAT_W'(BEATS - 1)) begin
               train_done = 1'b1;
               beat_d     = '0;
               state_d    = IDLE;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy     = (state_q == UPDATE);
   assign busy_row = row_q;

   // ------------------------------------------------------------------
   // Training threshold
   // ------------------------------------------------------------------
`ifdef PERCEPTRON_ADAPTIVE_THETA_EN
   localparam int TC_MAX    = 2**(TC_W-1) - 1;
   localparam int TC_MIN    = -(2**(TC_W-1));
   localparam int THETA_MAX = 2**(SUM_W-1) - 1;

   logic signed [TC_W-1:0] tc_q, tc_d;
   logic [SUM_W-1:0]       theta_q, theta_d;
   logic                   w_train_accept;

   assign w_train_accept = (state_q == IDLE) && train_valid && w_need_train;

   // Mispredicts push the threshold up, low-confidence correct predictions
   // push it down; the counter restarts from zero each time it fires.
   always_comb begin
      tc_d    = tc_q;
      theta_d = theta_q;
      if (w_train_accept) begin
         if (w_mispredict) begin
            if (tc_q == TC_W'(TC_MAX - 1)) begin
               tc_d = '0;
               if (theta_q != SUM_W'(THETA_MAX)) begin
                  theta_d = theta_q + SUM_W'(1);
               end
            end else begin
               tc_d = tc_q + TC_W'(1);
            end
         end else begin
            if (tc_q == TC_W'(TC_MIN + 1)) begin
               tc_d = '0;
               if (theta_q > SUM_W'(1)) begin
                  theta_d = theta_q - SUM_W'(1);
               end
            end else begin
               tc_d = tc_q - TC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tc_q    <= '0;
         theta_q <= SUM_W'(THETA);
      end else begin
         tc_q    <= tc_d;
         theta_q <= theta_d;
      end
   end

   assign w_theta = theta_q;
`else
   logic w_unused_tc;
   assign w_unused_tc = ^TC_W'(0);
   assign w_theta     = SUM_W'(THETA);
`endif

   assign cur_theta = w_theta;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_table_trainer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perceptron_table_trainer
//  Description : Self-checking bench for perceptron_table_trainer. A
//                behavioural model (plain integer arrays) tracks the table,
//                the rewrite in progress and the threshold; every cycle the
//                DUT outputs are compared against it. Directed sequences pin
//                the model with hand-computed values, then randomized
//                requests run against the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron_table_trainer;
   import perceptron_pkg::*;

   localparam int LIM = 2**(DEF_WIDTH-1) - 1;

   logic                          clk = 1'b0;
   logic                          rst = 1'b0;
   logic [IDX_W-1:0]              pred_row;
   logic [NUM_W*DEF_WIDTH-1:0]    pred_weights;
   logic                          train_valid;
   logic                          train_ready;
   logic [IDX_W-1:0]              train_row;
   logic [DEF_HIST_LEN-1:0]       train_history;
   logic                          train_outcome;
   logic [SUM_W-1:0]              train_sum;
   logic                          busy;
   logic [IDX_W-1:0]              busy_row;
   logic                          train_done;
   logic [SUM_W-1:0]              cur_theta;

   perceptron_table_trainer dut (
      .clk           (clk),
      .rst           (rst),
      .pred_row      (pred_row),
      .pred_weights  (pred_weights),
      .train_valid   (train_valid),
      .train_ready   (train_ready),
      .train_row     (train_row),
      .train_history (train_history),
      .train_outcome (train_outcome),
      .train_sum     (train_sum),
      .busy          (busy),
      .busy_row      (busy_row),
      .train_done    (train_done),
      .cur_theta     (cur_theta)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int dut_w(input int k);
      return int'($signed(pred_weights[k*DEF_WIDTH +: DEF_WIDTH]));
   endfunction

   // Every weight of the row on pred_row must equal one literal value.
   task automatic chk_row_const(input string nm, input int v);
      int bad;
      bad = 0;
      for (int k = 0; k < NUM_W; k++) begin
         if (dut_w(k) != v && bad == 0) bad = k;
      end
      chk(nm, dut_w(bad), v);
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   int m_w [DEF_ROWS][NUM_W];
   int m_x [NUM_W];
   int m_t;
   int m_row;
   int m_left;        // write beats still to go for the accepted job
   int m_theta;
   int m_tc;
   int m_accepts = 0; // every consumed request, trained or not
   int m_b;
   int m_s;
   int m_abs;
   bit m_mis;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEF_ROWS; r++)
            for (int k = 0; k < NUM_W; k++) m_w[r][k] = 0;
         m_left  = 0;
         m_row   = 0;
         m_theta = DEF_THETA;
         m_tc    = 0;
      end else if (m_left > 0) begin
         m_b = BEATS - m_left;
         for (int k = m_b*DEF_LANES; k < (m_b+1)*DEF_LANES && k < NUM_W; k++) begin
            m_w[m_row][k] = m_w[m_row][k] + m_t*m_x[k];
            if (m_w[m_row][k] >  LIM) m_w[m_row][k] =  LIM;
            if (m_w[m_row][k] < -LIM) m_w[m_row][k] = -LIM;
         end
         m_left--;
      end else if (train_valid) begin
         m_accepts++;
         m_s   = int'($signed(train_sum));
         m_mis = ((m_s >= 0) ? 1'b1 : 1'b0) != train_outcome;
         m_abs = (m_s < 0) ? -m_s : m_s;
         if (m_mis || m_abs <= m_theta) begin
            m_row  = int'(train_row);
            m_t    = train_outcome ? 1 : -1;
            m_x[0] = 1;
            for (int k = 1; k < NUM_W; k++) m_x[k] = train_history[k-1] ? 1 : -1;
            m_left = BEATS;
`ifdef PERCEPTRON_ADAPTIVE_THETA_EN
            if (m_mis) begin
               m_tc++;
               if (m_tc == 2**(DEF_TC_W-1) - 1) begin
                  m_tc = 0;
                  if (m_theta < 2**(SUM_W-1) - 1) m_theta++;
               end
            end else begin
               m_tc--;
               if (m_tc == -(2**(DEF_TC_W-1))) begin
                  m_tc = 0;
                  if (m_theta > 1) m_theta--;
               end
            end
`endif
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle comparison against the model
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      int pr;
      int bad;
      chk("train_ready", train_ready, m_left == 0);
      chk("busy", busy, m_left > 0);
      if (m_left > 0) chk("busy_row", busy_row, m_row);
      chk("train_done", train_done, m_left == 1);
      chk("cur_theta", cur_theta, m_theta);
      pr  = int'(pred_row);
      bad = 0;
      for (int k = 0; k < NUM_W; k++) begin
         if (dut_w(k) != m_w[pr][k] && bad == 0) bad = k;
      end
      chk("pred_weights", dut_w(bad), m_w[pr][bad]);
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic drive(input int row, input logic [DEF_HIST_LEN-1:0] h,
                        input logic o, input int s);
      train_row     = IDX_W'(row);
      train_history = h;
      train_outcome = o;
      train_sum     = SUM_W'(s);
      train_valid   = 1'b1;
   endtask

   // Returns at the negedge following the accepting clock edge.
   task automatic wait_accept(output int cyc);
      int a0;
      a0  = m_accepts;
      cyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m_accepts != a0) begin
            cyc = i;
            break;
         end
      end
      if (cyc < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got no accept, expected accept within 40 cycles");
      end
   endtask

   task automatic wait_idle();
      int ok;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m_left == 0) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL idle_timeout: got busy, expected idle within 40 cycles");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   localparam logic [DEF_HIST_LEN-1:0] ONES = '1;

   initial begin
      int c;
      int nb;
      int done_at;
      int acc2;
      int a1;
      int last_acc;
      int s;

      pred_row      = IDX_W'(5);
      train_valid   = 1'b0;
      train_row     = '0;
      train_history = '0;
      train_outcome = 1'b0;
      train_sum     = '0;

      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk_row_const("reset_row5_zero", 0);
      chk("reset_theta", cur_theta, 133);
      chk("reset_ready", train_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_busy_row", busy_row, 0);
      chk("reset_done", train_done, 0);

      // Row 3, all-ones history, taken, sum 0: low confidence -> trains.
      // A second request is held high while busy.
      #1 drive(3, ONES, 1'b1, 0);
      wait_accept(c);
      a1      = m_accepts;
      nb      = 0;
      done_at = -1;
      acc2    = -1;
      #1 drive(3, ONES, 1'b1, 200);
      for (int cy = 0; cy < 20; cy++) begin
         if (busy) nb++;
         if (train_done) done_at = cy;
         if (m_accepts != a1) begin
            acc2 = cy;
            break;
         end
         @(negedge clk);
      end
      #1 train_valid = 1'b0;
      chk("busy_cycles", nb, 4);
      chk("done_on_4th_busy_cycle", done_at, 3);
      chk("held_req_accept_cycle", acc2, 5);
      // Second request: confident correct prediction, consumed with no rewrite
      pred_row = IDX_W'(3);
      @(negedge clk);
      chk("no_busy_confident", busy, 0);
      chk_row_const("row3_all_plus1", 1);

      // Row 7 saturation: 130 taken trainings back to back
      for (int i = 0; i < 130; i++) begin
         #1 drive(7, ONES, 1'b1, 0);
         wait_accept(c);
      end
      #1 train_valid = 1'b0;
      pred_row = IDX_W'(7);
      wait_idle();
      @(negedge clk);
      chk_row_const("row7_sat_127", 127);
      #1 drive(7, ONES, 1'b0, 0);
      wait_accept(c);
      #1 train_valid = 1'b0;
      wait_idle();
      @(negedge clk);
      chk_row_const("row7_after_nt_126", 126);

      // Reset in the middle of a rewrite (beat 2)
      #1 drive(7, ONES, 1'b0, 0);
      wait_accept(c);
      #1 train_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midreset_busy", busy, 0);
      chk("midreset_ready", train_ready, 1);
      chk_row_const("midreset_row7_zero", 0);
      pred_row = IDX_W'(3);
      #1;
      chk_row_const("midreset_row3_zero", 0);
      @(negedge clk);
      #1 rst = 1'b0;

      // 63 consecutive mispredicts on row 9
      for (int i = 0; i < 63; i++) begin
         #1 drive(9, DEF_HIST_LEN'({$urandom(), $urandom()}), 1'b0, 0);
         wait_accept(c);
      end
      #1 train_valid = 1'b0;
      wait_idle();
`ifdef PERCEPTRON_ADAPTIVE_THETA_EN
      chk("theta_after_63_mispredicts", cur_theta, 134);
`else
      chk("theta_after_63_mispredicts", cur_theta, 133);
`endif

      // Randomized traffic
      last_acc = m_accepts;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         pred_row = IDX_W'($urandom_range(0, 7));
         if (i == 1000) begin
            rst = 1'b1;
            #2 rst = 1'b0;
         end
         if (!train_valid || m_accepts != last_acc) begin
            last_acc = m_accepts;
            if ($urandom_range(0, 3) == 0) begin
               train_valid = 1'b0;
            end else begin
               case ($urandom_range(0, 3))
                  0:       s = int'($urandom_range(0, 300)) - 150;
                  1:       s = int'($urandom_range(0, 32767)) - 16384;
                  2:       s = ($urandom_range(0, 1) == 1) ? 16383 : -16384;
                  default: s = 0;
               endcase
               drive(int'($urandom_range(0, 3)),
                     DEF_HIST_LEN'({$urandom(), $urandom()}),
                     1'($urandom_range(0, 1)), s);
            end
         end
      end
      #1 train_valid = 1'b0;
      wait_idle();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
